// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle CPU: word-addressed RAM plus an MMIO page
// holding a free-running cycle counter and a FIFO-buffered UART transmitter.
`timescale 1ns/1ps
module dmem_mmio #(
  parameter int DEPTH        = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        uart_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0] UART_DATA = 32'hFFFF_0000;
  localparam logic [31:0] UART_STAT = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE     = 32'hFFFF_0008;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [31:0]   mem [DEPTH];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   count;
  logic          ovf;
  logic [31:0]   cycle_cnt;
  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          wr_en, ram_sel, sel_data, sel_stat, sel_cycle;
  logic [AW-1:0] ram_idx;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic          full, empty, busy, pop, push_req, push, overflow, baud_end;

  assign wr_en     = (MemWrite != 2'b00);
  assign ram_sel   = (addr[31:AW+2] == '0);
  assign ram_idx   = addr[AW+1:2];
  assign sel_data  = (addr == UART_DATA);
  assign sel_stat  = (addr == UART_STAT);
  assign sel_cycle = (addr == CYCLE);

  // Byte enables; misaligned word/half stores leave be at zero so nothing is written.
  always_comb begin
    be    = 4'b0000;
    wword = writedata;
    case (MemWrite)
      2'b01: if (addr[1:0] == 2'b00) be = 4'b1111;
      2'b10: begin
        wword = {2{writedata[15:0]}};
        if (!addr[0]) be = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b11: begin
        wword = {4{writedata[7:0]}};
        be    = 4'b0001 << addr[1:0];
      end
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign full     = (count == (FW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != ST_IDLE) || !empty;
  assign pop      = (state == ST_IDLE) && !empty;
  assign push_req = wr_en && sel_data;
  assign push     = push_req && (!full || pop);
  assign overflow = push_req && !push;

  always_comb begin
    readdata = 32'h0;
    if (ram_sel)        readdata = mem[ram_idx];
    else if (sel_stat)  readdata = {29'b0, ovf, full, busy};
    else if (sel_cycle) readdata = cycle_cnt;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= writedata[7:0];
  end

  // A new overflow wins over a status-register clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf <= overflow || (ovf && !(wr_en && sel_stat));
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    cycle_cnt <= 32'h0;
    else if (wr_en && sel_cycle) cycle_cnt <= 32'h0;
    else                        cycle_cnt <= cycle_cnt + 32'h1;
  end

  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          shift    <= fifo[rd_ptr];
          baud_cnt <= '0;
          state    <= ST_START;
        end
        ST_START: if (baud_end) begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= ST_DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        ST_DATA: if (baud_end) begin
          baud_cnt <= '0;
          shift    <= shift >> 1;
          if (bit_idx == 3'd7) state <= ST_STOP;
          else bit_idx <= bit_idx + 1'b1;
        end else baud_cnt <= baud_cnt + 1'b1;
        default: if (baud_end) begin
          baud_cnt <= '0;
          state    <= ST_IDLE;
        end else baud_cnt <= baud_cnt + 1'b1;
      endcase
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: vector table for RAM lanes and decode, byte-array RAM model,
// serial receiver with an expected-byte queue, and hand sequences for UART/CYCLE/reset corners.
`timescale 1ns/1ps
module tb_dmem_mmio;
  localparam int DEPTH = 256;
  localparam int FIFO_DEPTH = 8;
  localparam int CPB = 4;
  localparam logic [31:0] A_DATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mem_write = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        uart_tx;

  dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .MemWrite(mem_write), .addr(addr),
    .writedata(writedata), .readdata(readdata), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-level RAM model, little-endian lanes.
  logic [7:0] mdl [4*DEPTH];

  function automatic void mdl_write(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
    if (mw == 2'b00 || a >= 32'(4*DEPTH)) return;
    case (mw)
      2'b01: if (a % 4 == 0) for (int i = 0; i < 4; i++) mdl[a+i] = d[8*i +: 8];
      2'b10: if (a % 2 == 0) begin mdl[a] = d[7:0]; mdl[a+1] = d[15:8]; end
      default: mdl[a] = d[7:0];
    endcase
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'h3;
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  task automatic bus_wr(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
    mem_write = mw; addr = a; writedata = d;
    mdl_write(mw, a, d);
    @(negedge clk);
    mem_write = 2'b00;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = readdata;
  endtask

  task automatic idle(input int n);
    mem_write = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  // Serial receiver: samples mid-bit and scores each frame against exp_q.
  logic [7:0] exp_q[$];
  logic       rx_en = 1'b0;
  int         rx_frames = 0;
  logic [7:0] rx_byte;

  initial forever begin
    @(negedge clk);
    if (rx_en && uart_tx == 1'b0) begin
      repeat (CPB/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_byte[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      check("rx_stop", {31'b0, uart_tx}, 32'h1);
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rx_unexpected: got 0x%02h expected no frame", rx_byte);
      end else begin
        check("rx_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
      end
      rx_frames++;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rx_frame_count", rx_frames, n);
  endtask

  typedef struct {
    logic [1:0]  mw;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[16];
  logic [31:0] d;
  logic [31:0] ra;
  logic        exp_bits[$];
  logic [7:0]  b8;
  int          total_frames;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{2'b11, 32'h11,         32'h1234_56AA, 32'h10,         32'h1122_AA44};
    vt[1]  = '{2'b10, 32'h12,         32'hDEAD_BEEF, 32'h10,         32'hBEEF_AA44};
    vt[2]  = '{2'b10, 32'h13,         32'h0000_1111, 32'h10,         32'hBEEF_AA44};
    vt[3]  = '{2'b01, 32'h12,         32'h0000_0000, 32'h10,         32'hBEEF_AA44};
    vt[4]  = '{2'b01, 32'h11,         32'h0000_0000, 32'h10,         32'hBEEF_AA44};
    vt[5]  = '{2'b11, 32'h10,         32'hFFFF_FF77, 32'h10,         32'hBEEF_AA77};
    vt[6]  = '{2'b10, 32'h10,         32'hAAAA_1234, 32'h10,         32'hBEEF_1234};
    vt[7]  = '{2'b11, 32'h13,         32'h0000_0099, 32'h10,         32'h99EF_1234};
    vt[8]  = '{2'b01, 32'h14,         32'hCAFE_F00D, 32'h14,         32'hCAFE_F00D};
    vt[9]  = '{2'b00, 32'h10,         32'h0000_0000, 32'h10,         32'h99EF_1234};
    vt[10] = '{2'b01, 32'h410,        32'hDEAD_0000, 32'h410,        32'h0000_0000};
    vt[11] = '{2'b01, 32'h8000_0010,  32'h0000_0BAD, 32'h10,         32'h99EF_1234};
    vt[12] = '{2'b11, 32'hFFFF_000C,  32'h0000_00FF, 32'hFFFF_000C,  32'h0000_0000};
    vt[13] = '{2'b00, 32'h0,          32'h0,         32'hFFFF_0000,  32'h0000_0000};
    vt[14] = '{2'b11, 32'hFFFF_0001,  32'h0000_0041, 32'hFFFF_0004,  32'h0000_0000};
    vt[15] = '{2'b01, 32'h3FC,        32'h0BAD_F00D, 32'h3FC,        32'h0BAD_F00D};

    // Reset and first cycle after it
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    rd(A_CYC, d);  check("cycle_after_rst", d, 32'h0);
    rd(A_STAT, d); check("stat_after_rst", d, 32'h0);
    check("tx_after_rst", {31'b0, uart_tx}, 32'h1);
    bus_wr(2'b01, 32'h10, 32'h1122_3344);
    rd(32'h10, d); check("sw_word", d, 32'h1122_3344);
    rd(A_CYC, d);  check("cycle_one", d, 32'h1);

    // Read during write returns the old word
    mem_write = 2'b01; addr = 32'h10; writedata = 32'h5A5A_5A5A;
    #1; check("rdw_old", readdata, 32'h1122_3344);
    mdl_write(2'b01, 32'h10, 32'h5A5A_5A5A);
    @(negedge clk); mem_write = 2'b00;
    rd(32'h10, d); check("rdw_new", d, 32'h5A5A_5A5A);
    bus_wr(2'b01, 32'h10, 32'h1122_3344);

    // Lane selection, misalignment, decode table
    for (int i = 0; i < 16; i++) begin
      bus_wr(vt[i].mw, vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, d);
      check($sformatf("vec%0d", i), d, vt[i].exp);
    end

    // Single frame waveform, 0x55
    exp_bits.delete();
    exp_bits.push_back(1'b1);
    repeat (CPB) exp_bits.push_back(1'b0);
    b8 = 8'h55;
    for (int b = 0; b < 8; b++) repeat (CPB) exp_bits.push_back(b8[b]);
    repeat (CPB) exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    bus_wr(2'b11, A_DATA, 32'h0000_0055);
    for (int i = 0; i < exp_bits.size(); i++) begin
      rd(A_STAT, d);
      check($sformatf("tx55_bit%0d", i), {31'b0, uart_tx}, {31'b0, exp_bits[i]});
      check($sformatf("tx55_busy%0d", i), {31'b0, d[0]}, (i == exp_bits.size()-1) ? 32'h0 : 32'h1);
      @(negedge clk);
    end

    // Ten back-to-back pushes: nine accepted, tenth overflows
    rx_en = 1'b1;
    total_frames = 0;
    for (int i = 0; i < 10; i++) begin
      b8 = 8'(8'hA0 + i);
      bus_wr(2'b11, A_DATA, {24'hFFFFFF, b8});
      if (i < 9) exp_q.push_back(b8);
    end
    rd(A_STAT, d); check("stat_ovf", d, 32'h7);
    bus_wr(2'b01, A_STAT, 32'h0);
    rd(A_STAT, d); check("stat_ovf_clr", d, 32'h3);
    total_frames += 9;
    wait_frames(total_frames, 2000);
    idle(CPB + 2);
    rd(A_STAT, d); check("stat_drained", d, 32'h0);

    // Push into a full FIFO on the cycle IDLE pops is accepted; the next one is not
    for (int i = 0; i < 9; i++) begin
      b8 = 8'(8'h30 + i);
      bus_wr(2'b10, A_DATA, {24'h0, b8});
      exp_q.push_back(b8);
    end
    idle(10*CPB + 2 - 9);
    bus_wr(2'b01, A_DATA, 32'h0000_00C3);
    exp_q.push_back(8'hC3);
    rd(A_STAT, d); check("full_pop_push", d, 32'h3);
    bus_wr(2'b11, A_DATA, 32'h0000_00EE);
    rd(A_STAT, d); check("full_no_pop", d, 32'h7);
    bus_wr(2'b11, A_STAT, 32'h0);
    total_frames += 10;
    wait_frames(total_frames, 3000);
    idle(CPB + 2);

    // Random bursts through the serial line
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, FIFO_DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        b8 = 8'($urandom);
        bus_wr(2'($urandom_range(1, 3)), A_DATA, {24'($urandom), b8});
        exp_q.push_back(b8);
      end
      total_frames += n;
      wait_frames(total_frames, 2000);
      idle(CPB + 2);
    end
    rd(A_STAT, d); check("stat_after_random", d, 32'h0);
    rx_en = 1'b0;

    // Cycle counter load and wrap
    bus_wr(2'b01, A_CYC, 32'hFFFF_FFFF);
    rd(A_CYC, d); check("cyc_load0", d, 32'h0);
    idle(32'h1234);
    rd(A_CYC, d); check("cyc_1234", d, 32'h1234);
    bus_wr(2'b11, A_CYC, 32'h0);
    rd(A_CYC, d); check("cyc_wr_zero", d, 32'h0);
    idle(1);
    rd(A_CYC, d); check("cyc_after_zero", d, 32'h1);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    idle(1);
    rd(A_CYC, d); check("cyc_max", d, 32'hFFFF_FFFF);
    idle(1);
    rd(A_CYC, d); check("cyc_wrap", d, 32'h0);

    // Random RAM traffic against the byte model
    for (int w = 0; w < 16; w++) bus_wr(2'b01, 32'(4*w), $urandom);
    for (int i = 0; i < 200; i++) begin
      bus_wr(2'($urandom_range(1, 3)), 32'($urandom_range(0, 63)), $urandom);
      ra = 32'($urandom_range(0, 15) * 4);
      rd(ra, d);
      check($sformatf("rand_ram%0d", i), d, mdl_word(ra));
    end

    // Reset mid-frame during data bit 3 of 0xF7
    bus_wr(2'b11, A_DATA, 32'h0000_00F7);
    idle(18);
    check("tx_bit3", {31'b0, uart_tx}, 32'h0);
    rst = 1'b1;
    idle(1);
    check("tx_rst_high", {31'b0, uart_tx}, 32'h1);
    rd(A_STAT, d); check("stat_rst", d, 32'h0);
    rd(A_CYC, d);  check("cyc_rst", d, 32'h0);
    rst = 1'b0;
    rd(32'h10, d); check("ram_retained", d, mdl_word(32'h10));
    rd(32'h8000_0000, d); check("unmapped_rd", d, 32'h0);
    rd(32'(4*DEPTH), d);  check("ram_end_rd", d, 32'h0);
    idle(3*CPB);
    check("tx_abandoned", {31'b0, uart_tx}, 32'h1);
    rd(A_STAT, d); check("stat_abandoned", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
